// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the LSU memory-interface stage: FSM state
// encoding, access-size codes, default watchdog limit and the alignment check.
package lsu_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        LsuIdle = 2'b00,
        LsuReq  = 2'b01,
        LsuResp = 2'b10,
        LsuDone = 2'b11
    } lsu_state_e;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    localparam int unsigned LSU_TIMEOUT_DEF = 64;

    // Size 11 has no legal encoding, so it is reported as misaligned.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        mis = 1'b0;
        if (size == LSU_SIZE_H && lsb[0]) mis = 1'b1;
        if (size == LSU_SIZE_W && lsb != 2'b00) mis = 1'b1;
        if (size == 2'b11) mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_timeout_cnt.sv
// Response watchdog counter: cleared when a transaction starts, counts every
// cycle the FSM spends waiting on the bus, and flags the cycle that would make
// the total reach LIMIT so the FSM can abort in that same cycle.
module lsu_timeout_cnt #(
    parameter int unsigned LIMIT = 64,
    parameter int unsigned W     = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturating increment so a stuck enable can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && cnt_q != W'(LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = i_en && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory-interface stage: runs one valid/ready bus transaction per
// load/store, stalls the core while it is in flight and returns the raw read
// word. Optional build macro LSU_MISALIGN_TRAP_EN completes misaligned
// accesses immediately with an error instead of issuing them on the bus.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_DEF,
    parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_strb,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_ld_valid,
    output logic [31:0] o_ld_data,
    output logic        o_err,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_strb,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_e  state_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_strb_q;
    logic        done_q;
    logic        err_q;
    logic        ld_valid_q;
    logic [31:0] ld_data_q;
    logic        stall;
    logic        to_clr;
    logic        to_en;
    logic        to_tc;
    logic        misaligned;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = lsu_misaligned(i_req_size, i_req_addr[1:0]);
`else
    // Without the trap the size code and low address bits are not needed.
    logic unused_req_bits;
    assign unused_req_bits = ^{i_req_size, i_req_addr[1:0]};
    assign misaligned      = 1'b0;
`endif

    assign to_clr = (state_q == LsuIdle) && i_req_valid;
    assign to_en  = (state_q == LsuReq) || (state_q == LsuResp);

    lsu_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC),
        .W     (TO_W)
    ) u_timeout_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (to_clr),
        .i_en  (to_en),
        .o_tc  (to_tc)
    );

    // Transaction FSM; all completion and bus outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= LsuIdle;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ld_valid_q <= 1'b0;
            unique case (state_q)
                LsuIdle: begin
                    if (i_req_valid) begin
                        mem_we_q    <= i_req_we;
                        mem_addr_q  <= {i_req_addr[31:2], 2'b00};
                        mem_wdata_q <= i_req_wdata;
                        mem_strb_q  <= i_req_we ? i_req_strb : 4'b0000;
                        if (misaligned) begin
                            state_q   <= LsuDone;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            ld_data_q <= '0;
                        end else begin
                            state_q     <= LsuReq;
                            mem_valid_q <= 1'b1;
                        end
                    end
                end
                LsuReq: begin
                    // The watchdog wins over a same-cycle handshake.
                    if (to_tc) begin
                        state_q     <= LsuDone;
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        ld_data_q   <= '0;
                    end else if (i_mem_ready) begin
                        mem_valid_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q <= LsuDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LsuResp;
                        end
                    end
                end
                LsuResp: begin
                    if (to_tc) begin
                        state_q   <= LsuDone;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        ld_data_q <= '0;
                    end else if (i_mem_rvalid) begin
                        state_q    <= LsuDone;
                        done_q     <= 1'b1;
                        ld_valid_q <= 1'b1;
                        ld_data_q  <= i_mem_rdata;
                    end
                end
                LsuDone: begin
                    // A request seen here is the instruction just completed.
                    state_q <= LsuIdle;
                end
                default: state_q <= LsuIdle;
            endcase
        end
    end

    // Stall decode; in IDLE it follows the incoming request directly.
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            LsuIdle:         stall = i_req_valid;
            LsuReq, LsuResp: stall = 1'b1;
            LsuDone:         stall = 1'b0;
            default:         stall = 1'b0;
        endcase
    end

    assign o_stall     = stall;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_ld_valid  = ld_valid_q;
    assign o_ld_data   = ld_data_q;
    assign o_mem_valid = mem_valid_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_strb  = mem_strb_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with an 8-cycle watchdog.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        stall;
    logic        done;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_mem_ctrl #(
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_we     (req_we),
        .i_req_size   (req_size),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_strb   (req_strb),
        .o_stall      (stall),
        .o_done       (done),
        .o_ld_valid   (ld_valid),
        .o_ld_data    (ld_data),
        .o_err        (err),
        .o_mem_valid  (mem_valid),
        .i_mem_ready  (mem_ready),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_strb   (mem_strb),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sb);
        req_valid = v;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        req_strb  = sb;
    endtask

    // Completion pulse outputs in one go.
    task automatic chk_cpl(input string tag, input logic d, input logic e, input logic lv);
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
        chk({tag, ".ld_valid"}, {31'd0, ld_valid}, {31'd0, lv});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst        = 1'b1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        tick();
        tick();

        // Reset state
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk_cpl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.ld_data", ld_data, 32'h0);
        rst = 1'b0;
        tick();

        // 1: sw 0x100, immediate ready
        set_req(1'b1, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 4'hF);
        mem_ready = 1'b1;
        #1;
        chk("sw.idle_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("sw.req_valid", {31'd0, mem_valid}, 32'd1);
        chk("sw.addr", mem_addr, 32'h100);
        chk("sw.we", {31'd0, mem_we}, 32'd1);
        chk("sw.wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw.strb", {28'd0, mem_strb}, 32'hF);
        chk("sw.req_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("sw.done_stall", {31'd0, stall}, 32'd0);
        chk_cpl("sw.cpl", 1'b1, 1'b0, 1'b0);
        chk("sw.done_mv", {31'd0, mem_valid}, 32'd0);
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        mem_ready = 1'b0;
        tick();
        chk("sw.idle_done", {31'd0, done}, 32'd0);

        // 2: lw 0x204, ready after 3 wait cycles, rvalid 2 cycles after accept
        set_req(1'b1, 1'b0, 2'b10, 32'h204, 32'h11111111, 4'hF);
        tick();
        chk("lw.strb", {28'd0, mem_strb}, 32'h0);
        chk("lw.addr", mem_addr, 32'h204);
        chk("lw.we", {31'd0, mem_we}, 32'd0);
        tick();
        tick();
        chk("lw.wait_valid", {31'd0, mem_valid}, 32'd1);
        chk("lw.wait_addr", mem_addr, 32'h204);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("lw.resp_mv", {31'd0, mem_valid}, 32'd0);
        chk("lw.resp_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lw.resp2_stall", {31'd0, stall}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        chk("lw.data", ld_data, 32'h12345678);
        chk_cpl("lw.cpl", 1'b1, 1'b0, 1'b1);
        chk("lw.done_stall", {31'd0, stall}, 32'd0);
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        tick();
        chk("lw.hold_data", ld_data, 32'h12345678);
        chk("lw.ldv_drop", {31'd0, ld_valid}, 32'd0);

        // 3: lb 0x203; request still present in DONE must not start a new access
        set_req(1'b1, 1'b0, 2'b00, 32'h203, 32'h0, 4'h1);
        mem_ready = 1'b1;
        tick();
        chk("lb.addr", mem_addr, 32'h200);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5A5A5;
        tick();
        mem_rvalid = 1'b0;
        chk("lb.data", ld_data, 32'hA5A5A5A5);
        chk_cpl("lb.cpl", 1'b1, 1'b0, 1'b1);
        tick();
        chk("lb.no_reissue", {31'd0, mem_valid}, 32'd0);
        chk("lb.idle_done", {31'd0, done}, 32'd0);
        set_req(1'b1, 1'b1, 2'b10, 32'h300, 32'h01020304, 4'h3);
        tick();
        chk("next.valid", {31'd0, mem_valid}, 32'd1);
        chk("next.addr", mem_addr, 32'h300);
        chk("next.strb", {28'd0, mem_strb}, 32'h3);
        tick();
        chk_cpl("next.cpl", 1'b1, 1'b0, 1'b0);
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        mem_ready = 1'b0;
        tick();

        // 4: load accepted but rvalid never comes; stray rvalid in IDLE/REQ ignored
        set_req(1'b1, 1'b0, 2'b10, 32'h400, 32'h0, 4'h0);
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            mem_ready = 1'b0;
            chk("to.wait_stall", {31'd0, stall}, 32'd1);
            chk("to.wait_done", {31'd0, done}, 32'd0);
        end
        tick();
        chk_cpl("to.cpl", 1'b1, 1'b1, 1'b0);
        chk("to.data", ld_data, 32'h0);
        chk("to.mv", {31'd0, mem_valid}, 32'd0);
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        chk("to.late_data", ld_data, 32'h0);
        chk_cpl("to.late", 1'b0, 1'b0, 1'b0);

        // 4b: store never accepted; valid must drop at the timeout
        set_req(1'b1, 1'b1, 2'b10, 32'h440, 32'h77777777, 4'hF);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("tos.valid_held", {31'd0, mem_valid}, 32'd1);
        end
        tick();
        chk_cpl("tos.cpl", 1'b1, 1'b1, 1'b0);
        chk("tos.mv", {31'd0, mem_valid}, 32'd0);
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        tick();

        // 5: reset while in RESP, then a clean load
        set_req(1'b1, 1'b0, 2'b10, 32'h500, 32'h0, 4'h0);
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cpl("rr.cpl", 1'b0, 1'b0, 1'b0);
        chk("rr.mv", {31'd0, mem_valid}, 32'd0);
        chk("rr.addr", mem_addr, 32'h0);
        chk("rr.stall", {31'd0, stall}, 32'd0);
        set_req(1'b1, 1'b0, 2'b10, 32'h504, 32'h0, 4'h0);
        mem_ready = 1'b1;
        tick();
        chk("rr.new_addr", mem_addr, 32'h504);
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADCAFE;
        tick();
        mem_rvalid = 1'b0;
        chk("rr.data", ld_data, 32'h0BADCAFE);
        chk_cpl("rr.new_cpl", 1'b1, 1'b0, 1'b1);
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        tick();

        // 6: lw at 0x102
        set_req(1'b1, 1'b0, 2'b10, 32'h102, 32'h0, 4'h0);
        mem_ready = 1'b1;
        #1;
        chk("mis.idle_stall", {31'd0, stall}, 32'd1);
        tick();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis.mv", {31'd0, mem_valid}, 32'd0);
        chk_cpl("mis.cpl", 1'b1, 1'b1, 1'b0);
        chk("mis.stall", {31'd0, stall}, 32'd0);
`else
        chk("mis.mv", {31'd0, mem_valid}, 32'd1);
        chk("mis.addr", mem_addr, 32'h100);
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        tick();
        mem_rvalid = 1'b0;
        chk("mis.data", ld_data, 32'h55AA55AA);
        chk_cpl("mis.cpl", 1'b1, 1'b0, 1'b1);
`endif
        set_req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
        mem_ready = 1'b0;
        tick();
        chk("end.done", {31'd0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequential memory-interface stage directly downstream of the LSU data handler.
- Takes the lane-aligned store data/strobe or load request, runs one transaction on a valid/ready data-memory bus and stalls the core while it is in flight.
- Returns the raw 32-bit read word to the handler for sign/zero extension and lane selection.
- Includes a response-timeout watchdog.

Parameters:
- TIMEOUT_CYC, 64: cycles spent in REQ+RESP before an aborted transaction is flagged as an error (≥2).
- TO_W, $clog2(TIMEOUT_CYC+1): timeout counter width.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  load/store present in stage
- i_req_we  in  1  1=store, 0=load
- i_req_size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  lane-aligned store data
- i_req_strb  in  4  byte strobe
- o_stall  out  1  freeze upstream pipeline
- o_done  out  1  one-cycle completion pulse
- o_ld_valid  out  1  o_ld_data valid (load completion)
- o_ld_data  out  32  raw read word to the handler
- o_err  out  1  error on this completion (timeout or misalign)
- o_mem_valid  out  1  bus request valid
- i_mem_ready  in  1  bus accepts request
- o_mem_we  out  1  bus write enable
- o_mem_addr  out  32  word address {addr[31:2],2'b00}
- o_mem_wdata  out  32  write data
- o_mem_strb  out  4  write strobe (0000 for loads)
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  32  read data

Behaviour:
- Clocking and reset:
  - One clock (i_clk); reset is synchronous and active-high (i_rst).
  - On reset: state=IDLE and every output is 0 (o_ld_data=0, o_mem_*=0), counter cleared.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On i_req_valid, register we/size/addr/wdata/strb and go to REQ.
  - o_stall = i_req_valid (combinational) in IDLE.
- REQ:
  - o_mem_valid=1; request fields are held stable until i_mem_ready.
  - On ready: a store goes to DONE; a load goes to RESP.
- RESP:
  - Wait for i_mem_rvalid, then capture i_mem_rdata into o_ld_data and go to DONE.
  - i_mem_rvalid is honoured only in RESP. The bus returns data ≥1 cycle after acceptance; rvalid in any other state is ignored.
- DONE:
  - o_stall=0, o_done=1; o_ld_valid=1 for a load without error.
  - Next state is IDLE.
  - i_req_valid is ignored in DONE because it still belongs to the completed instruction.
- Stall: o_stall=1 in REQ and RESP.
- Latency:
  - Store with immediate ready: 2 stall cycles.
  - Load with ready, then rvalid next cycle: 3 stall cycles.
- Timeout:
  - Counter clears on IDLE→REQ and increments each cycle in REQ/RESP.
  - When it equals TIMEOUT_CYC: drop o_mem_valid, go to DONE with o_err=1, o_ld_valid=0, o_ld_data=0.
  - A late rvalid after the timeout is ignored.
- o_ld_data holds its last value outside of load completions.
- Reset mid-transaction: back to IDLE next edge, o_mem_valid low and no o_done. Bus-side cleanup is the memory's responsibility.
- o_err is asserted only in DONE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠00, is detected in IDLE.
  - The FSM goes IDLE→DONE directly with no bus request, o_err=1 and o_ld_valid=0 (1 stall cycle).
  - Size 11 is treated as misaligned.
- Undefined:
  - No check; the low address bits are dropped on o_mem_addr and all accesses go to the bus.

Decomposition:
- singlecycle_pkg gains:
  - lsu_state_e (IDLE/REQ/RESP/DONE)
  - LSU_SIZE_B/H/W constants (2'b00/01/10)
  - LSU_TIMEOUT_DEF=64
- The timeout counter is the natural sub-module: lsu_timeout_cnt (clear, enable, terminal-count flag).

Test Plan:
1. sw, addr 0x100, wdata 0xDEADBEEF, strb 1111, ready=1 on the first REQ cycle → o_mem_addr=0x100, o_mem_we=1, o_stall high for 2 cycles, o_done pulse, o_err=0.
2. lw, addr 0x204, ready after 3 wait cycles, rvalid 2 cycles later with 0x12345678 → o_mem_strb=0000, o_ld_data=0x12345678, o_ld_valid pulse in DONE, stall released the same cycle.
3. lb, addr 0x203 → o_mem_addr=0x200. The request is still held in the DONE cycle; the next instruction is accepted only in the following IDLE, giving exactly one bus transaction per instruction.
4. Load with rvalid never asserted, TIMEOUT_CYC=8 → DONE after 8 cycles in REQ/RESP with o_err=1, o_ld_valid=0. An rvalid injected one cycle later is ignored.
5. i_rst asserted while in RESP → the next cycle is IDLE with all outputs 0 and no o_done. A fresh lw then completes normally.
6. With LSU_MISALIGN_TRAP_EN: lw at 0x102 → o_mem_valid never asserted, o_err=1 after 1 stall cycle. Without the macro: bus address 0x100, normal completion.
